// File: rtl/fft_host_ctrl_if.sv
// rtl/fft_host_ctrl_if.sv - sample streams, FFT RAM port and FFT control bundle
interface fft_host_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 11
);
  logic [DWIDTH-1:0] s_data_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic              inverse_i;
  logic [DWIDTH-1:0] m_data_o;
  logic              m_valid_o;
  logic              m_ready_i;
  logic              m_last_o;
  logic              busy_o;
  logic              o_ram_control;
  logic [AWIDTH-1:0] o_ram_address;
  logic [DWIDTH-1:0] o_ram_writedata;
  logic              o_ram_read;
  logic              o_ram_write;
  logic [DWIDTH-1:0] i_ram_readdata;
  logic              i_ram_waitrequest;
  logic              i_ram_readdatavalid;
  logic              o_start;
  logic              o_inverse;
  logic              i_finish;

  modport master (
    input  s_data_i, s_valid_i, inverse_i, m_ready_i,
           i_ram_readdata, i_ram_waitrequest, i_ram_readdatavalid, i_finish,
    output s_ready_o, m_data_o, m_valid_o, m_last_o, busy_o,
           o_ram_control, o_ram_address, o_ram_writedata, o_ram_read, o_ram_write,
           o_start, o_inverse
  );

  modport slave (
    output s_data_i, s_valid_i, inverse_i, m_ready_i,
           i_ram_readdata, i_ram_waitrequest, i_ram_readdatavalid, i_finish,
    input  s_ready_o, m_data_o, m_valid_o, m_last_o, busy_o,
           o_ram_control, o_ram_address, o_ram_writedata, o_ram_read, o_ram_write,
           o_start, o_inverse
  );
endinterface

// File: rtl/fft_host_ctrl.sv
// rtl/fft_host_ctrl.sv - loads a frame into FFT RAM, starts the core, streams the result back out
module fft_host_ctrl #(
  parameter int FFT_SIZE  = 1024,
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = $clog2(FFT_SIZE) + 1,
  parameter int MAX_OUTST = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  fft_host_ctrl_if.master bus
);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(FFT_SIZE - 1);
  localparam logic [AWIDTH-1:0] END_IDX  = AWIDTH'(FFT_SIZE);
  localparam logic [PW-1:0]     PTR_MAX  = PW'(MAX_OUTST - 1);
  localparam logic [CW:0]       CREDITS  = (CW + 1)'(MAX_OUTST);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_START, ST_WAIT, ST_UNLOAD
  } state_t;

  state_t state, state_nxt;

  logic [AWIDTH-1:0] widx, waddr, ridx, rcnt;
  logic [DWIDTH-1:0] wdata;
  logic              wr_req, inv_q, fin_q;
  logic [CW-1:0]     outst, count;
  logic [PW-1:0]     wptr, rptr;
  logic [DWIDTH:0]   fifo_mem [MAX_OUTST];

  logic              s_ready, rd_req, ram_ctrl, start;
  logic [AWIDTH-1:0] addr;
  logic              fin_rise, wr_done, s_acc, rd_acc, rdv, pop, fifo_valid;
  logic [CW:0]       occupancy;
  logic [DWIDTH:0]   fifo_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign fin_rise   = bus.i_finish & ~fin_q;
  assign wr_done    = wr_req & ~bus.i_ram_waitrequest;
  assign s_acc      = s_ready & bus.s_valid_i;
  assign rd_acc     = rd_req & ~bus.i_ram_waitrequest;
  // Beats returning outside UNLOAD belong to an abandoned frame.
  assign rdv        = (state == ST_UNLOAD) & bus.i_ram_readdatavalid;
  assign occupancy  = {1'b0, outst} + {1'b0, count};
  assign fifo_valid = (count != '0);
  assign fifo_head  = fifo_mem[rptr];
  assign pop        = fifo_valid & bus.m_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    rd_req    = 1'b0;
    ram_ctrl  = 1'b0;
    start     = 1'b0;
    addr      = '0;
    case (state)
      ST_IDLE: if (bus.s_valid_i) state_nxt = ST_LOAD;
      ST_LOAD: begin
        ram_ctrl = 1'b1;
        addr     = waddr;
        s_ready  = (widx != END_IDX) & (~wr_req | ~bus.i_ram_waitrequest);
        if (wr_done && waddr == LAST_IDX) state_nxt = ST_START;
      end
      ST_START: begin
        start     = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (fin_rise) state_nxt = ST_UNLOAD;
      ST_UNLOAD: begin
        ram_ctrl = 1'b1;
        addr     = ridx;
        // In-flight reads plus buffered bins never exceed the FIFO depth.
        rd_req   = (ridx != END_IDX) && (occupancy < CREDITS);
        if (pop && fifo_head[DWIDTH]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      widx   <= '0;
      waddr  <= '0;
      ridx   <= '0;
      rcnt   <= '0;
      wdata  <= '0;
      wr_req <= 1'b0;
      inv_q  <= 1'b0;
      fin_q  <= 1'b0;
      outst  <= '0;
      count  <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      fin_q <= bus.i_finish;
      if (state == ST_IDLE && bus.s_valid_i) begin
        inv_q <= bus.inverse_i;
        widx  <= '0;
        waddr <= '0;
      end
      if (s_acc) begin
        wr_req <= 1'b1;
        wdata  <= bus.s_data_i;
        waddr  <= widx;
        widx   <= widx + 1'b1;
      end else if (wr_done) begin
        wr_req <= 1'b0;
      end
      if (state == ST_WAIT && fin_rise) begin
        ridx  <= '0;
        rcnt  <= '0;
        outst <= '0;
      end
      if (rd_acc) ridx <= ridx + 1'b1;
      case ({rd_acc, rdv})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: ;
      endcase
      if (rdv) begin
        wptr <= ptr_inc(wptr);
        rcnt <= rcnt + 1'b1;
      end
      if (pop) rptr <= ptr_inc(rptr);
      case ({rdv, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Bit DWIDTH tags the final bin of the frame.
  always_ff @(posedge clk_i) begin
    if (rdv) fifo_mem[wptr] <= {rcnt == LAST_IDX, bus.i_ram_readdata};
  end

  assign bus.s_ready_o       = s_ready;
  assign bus.m_valid_o       = fifo_valid;
  assign bus.m_data_o        = fifo_valid ? fifo_head[DWIDTH-1:0] : '0;
  assign bus.m_last_o        = fifo_valid & fifo_head[DWIDTH];
  assign bus.busy_o          = (state != ST_IDLE);
  assign bus.o_ram_control   = ram_ctrl;
  assign bus.o_ram_address   = addr;
  assign bus.o_ram_writedata = wdata;
  assign bus.o_ram_read      = rd_req;
  assign bus.o_ram_write     = wr_req;
  assign bus.o_start         = start;
  assign bus.o_inverse       = inv_q;
endmodule
